// File: rtl/hex_display_scanner.sv
// hex_display_scanner: scans a 4*NUM_DIGITS-bit hex word onto a multiplexed
// active-low seven-segment display, one digit per PRESCALE clocks.
// A loaded word waits in a pending register and is promoted to the displayed
// (shadow) word only at a frame boundary, so a frame never mixes two words.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_display_scanner #(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 50000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int VW = 4 * NUM_DIGITS;
   // Keep counters at least one bit wide so PRESCALE=1 / NUM_DIGITS=1 still elaborate.
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] TICK_LAST  = CW'(PRESCALE - 1);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

   logic [CW-1:0]         tick_cnt;
   logic [DW-1:0]         digit_idx;
   logic [VW-1:0]         shadow;
   logic [VW-1:0]         pend_reg;
   logic                  tick;
   logic                  boundary;
   logic [3:0]            nibble;
   logic                  blank;
   logic [NUM_DIGITS-1:0] blank_mask;
   logic [NUM_DIGITS-1:0] an_next;
   logic [6:0]            seg_next;

   function automatic logic [6:0] decode(input logic [3:0] hex);
      logic [6:0] s;
      case (hex)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick     = (tick_cnt == TICK_LAST);
   assign boundary = tick && (digit_idx == DIGIT_LAST);

   // Prescaler: one tick every PRESCALE clocks.
   always_ff @(posedge clock) begin
      if (reset || tick) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + 1'b1;
   end

   // Digit pointer advances on each tick and wraps after the last digit.
   always_ff @(posedge clock) begin
      if (reset)     digit_idx <= '0;
      else if (tick) digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
   end

   // Load capture and frame-boundary promotion; a load on the boundary bypasses pend_reg.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_reg <= '0;
         pending  <= 1'b0;
         shadow   <= '0;
      end else begin
         if (load) pend_reg <= value;
         if (boundary && load) begin
            shadow  <= value;
            pending <= 1'b0;
         end else if (boundary) begin
            if (pending) shadow <= pend_reg;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit k blanks when it and every more significant nibble are zero; digit 0 never blanks.
   always_comb begin
      blank_mask = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         blank_mask[k] = ((shadow >> (4 * k)) == '0);
      end
   end
`else
   assign blank_mask = '0;
`endif

   // Select the active digit's nibble, enable and blank flag.
   always_comb begin
      nibble  = '0;
      blank   = 1'b0;
      an_next = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == DW'(i)) begin
            nibble     = shadow[4*i +: 4];
            blank      = blank_mask[i];
            an_next[i] = 1'b0;
         end
      end
      seg_next = blank ? 7'h7F : decode(nibble);
   end

   // Registered output stage, one clock behind the scan state.
   always_ff @(posedge clock) begin
      if (reset) begin
         seg        <= 7'h7F;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_next;
         an         <= an_next;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner at NUM_DIGITS=8, PRESCALE=2.
module tb_hex_display_scanner;

   localparam int N = 8;
   localparam int P = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load  = 1'b0;
   logic [31:0] value = '0;
   logic [6:0]  seg;
   logic [7:0]  an;
   logic        frame_done;
   logic        pending;

   int n_cmp  = 0;
   int n_fail = 0;

   hex_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
      .clock      (clock),
      .reset      (reset),
      .value      (value),
      .load       (load),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done),
      .pending    (pending)
   );

   always #5 clock = ~clock;

   // Reference model: k = clocks since reset released; digit shown and frame
   // boundary follow from plain arithmetic on k.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          k = 0;
   logic [31:0] m_shadow = '0;
   logic [31:0] m_pend = '0;
   logic        m_pending = 1'b0;
   logic [6:0]  e_seg = 7'h7F;
   logic [7:0]  e_an = 8'hFF;
   logic        e_fd = 1'b0;
   logic        e_pend = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LEAD_ZERO_SEG = 7'h7F;
`else
   localparam logic [6:0] LEAD_ZERO_SEG = 7'h40;
`endif

   function automatic logic [6:0] ref_seg(input logic [31:0] w, input int d);
      logic [31:0] upper;
      upper = w >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && upper == 0) return 7'h7F;
`endif
      return seg_tab[upper[3:0]];
   endfunction

   always @(posedge clock) begin
      int d;
      logic bnd;
      if (reset) begin
         k = 0; m_shadow = '0; m_pend = '0; m_pending = 1'b0;
         e_seg = 7'h7F; e_an = 8'hFF; e_fd = 1'b0; e_pend = 1'b0;
      end else begin
         d     = (k / P) % N;
         bnd   = ((k % (P * N)) == P * N - 1);
         e_an  = ~(8'b1 << d);
         e_seg = ref_seg(m_shadow, d);
         e_fd  = bnd;
         if (bnd) begin
            if (load)           m_shadow = value;
            else if (m_pending) m_shadow = m_pend;
            m_pending = 1'b0;
         end else if (load) begin
            m_pend = value;
            m_pending = 1'b1;
         end
         e_pend = m_pending;
         k = k + 1;
      end
   end

   task automatic test_reset();
      reset = 1'b1; load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({seg, an, frame_done, pending} !== {7'h7F, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got seg=%h an=%h fd=%b pend=%b want seg=7f an=ff fd=0 pend=0",
                     seg, an, frame_done, pending);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_scan_walk();
      logic [7:0] want_an;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         want_an = ~(8'b1 << ((i / P) % N));
         n_cmp++;
         if (an !== want_an || seg !== e_seg || frame_done !== e_fd || pending !== e_pend) begin
            n_fail++;
            $display("FAIL scan_walk[%0d]: got an=%h seg=%h fd=%b pend=%b want an=%h seg=%h fd=%b pend=%b",
                     i, an, seg, frame_done, pending, want_an, e_seg, e_fd, e_pend);
         end
      end
   endtask

   task automatic test_load_midframe();
      bit seen = 0;
      for (int g = 0; g < 32 && (k % (P * N)) != 4; g++) @(negedge clock);
      value = 32'h89ABCDEF; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      n_cmp++;
      if (pending !== 1'b1 || seg !== e_seg) begin
         n_fail++;
         $display("FAIL load_pending: got pend=%b seg=%h want pend=1 seg=%h", pending, seg, e_seg);
      end
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({seg, an, frame_done, pending} !== {e_seg, e_an, e_fd, e_pend}) begin
            n_fail++;
            $display("FAIL load_wait: got seg=%h an=%h fd=%b pend=%b want seg=%h an=%h fd=%b pend=%b",
                     seg, an, frame_done, pending, e_seg, e_an, e_fd, e_pend);
         end
         if (frame_done === 1'b1) seen = 1;
      end
      if (!seen) begin
         n_cmp++; n_fail++;
         $display("FAIL load_frame_done: got no frame_done within 40 cycles, want one");
      end
      for (int i = 0; i < 2 * N; i++) begin
         @(negedge clock);
         n_cmp++;
         if ((an === 8'hFE && seg !== 7'h0E) || (an === 8'h7F && seg !== 7'h00) || pending !== 1'b0
             || seg !== e_seg || an !== e_an) begin
            n_fail++;
            $display("FAIL load_show: got an=%h seg=%h pend=%b want an=%h seg=%h pend=0",
                     an, seg, pending, e_an, e_seg);
         end
      end
   endtask

   task automatic test_overwrite();
      int after = 0;
      for (int g = 0; g < 32 && (k % (P * N)) != 1; g++) @(negedge clock);
      value = 32'h11111111; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      @(negedge clock);
      value = 32'h22222222; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({seg, an, frame_done, pending} !== {e_seg, e_an, e_fd, e_pend}
             || (after > 0 && after <= 2 * N && seg !== 7'h24)) begin
            n_fail++;
            $display("FAIL overwrite: got seg=%h an=%h fd=%b pend=%b want seg=%h an=%h fd=%b pend=%b",
                     seg, an, frame_done, pending, e_seg, e_an, e_fd, e_pend);
         end
         if (after > 0) after++;
         if (frame_done === 1'b1 && after == 0) after = 1;
      end
   endtask

   task automatic test_load_on_boundary();
      for (int g = 0; g < 32 && (k % (P * N)) != P * N - 1; g++) @(negedge clock);
      value = 32'h00000005; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (pending !== 1'b0 || (an === 8'hFE && seg !== 7'h12)
             || {seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            n_fail++;
            $display("FAIL load_boundary: got seg=%h an=%h fd=%b pend=%b want seg=%h an=%h fd=%b pend=0",
                     seg, an, frame_done, pending, e_seg, e_an, e_fd);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset_midframe();
      for (int g = 0; g < 32 && (k % (P * N)) != 6; g++) @(negedge clock);
      value = 32'hDEADBEEF; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if ({seg, an, frame_done, pending} !== {7'h7F, 8'hFF, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_midframe: got seg=%h an=%h fd=%b pend=%b want seg=7f an=ff fd=0 pend=0",
                  seg, an, frame_done, pending);
      end
      @(negedge clock);
      n_cmp++;
      if (an !== 8'hFE || seg !== 7'h40 || pending !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_restart: got an=%h seg=%h pend=%b want an=fe seg=40 pend=0", an, seg, pending);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({seg, an, frame_done, pending} !== {e_seg, e_an, e_fd, e_pend}) begin
            n_fail++;
            $display("FAIL reset_scan: got seg=%h an=%h fd=%b pend=%b want seg=%h an=%h fd=%b pend=%b",
                     seg, an, frame_done, pending, e_seg, e_an, e_fd, e_pend);
         end
      end
   endtask

   task automatic test_blank();
      value = 32'h00000A30; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      for (int i = 0; i < 4 * P * N; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({seg, an, frame_done, pending} !== {e_seg, e_an, e_fd, e_pend}
             || (i >= 2 * P * N && an === 8'hF7 && seg !== LEAD_ZERO_SEG)
             || (i >= 2 * P * N && an === 8'hFB && seg !== 7'h08)) begin
            n_fail++;
            $display("FAIL blank: got seg=%h an=%h fd=%b pend=%b want seg=%h an=%h fd=%b pend=%b",
                     seg, an, frame_done, pending, e_seg, e_an, e_fd, e_pend);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({seg, an, frame_done, pending} !== {e_seg, e_an, e_fd, e_pend}) begin
            n_fail++;
            $display("FAIL random[%0d]: got seg=%h an=%h fd=%b pend=%b want seg=%h an=%h fd=%b pend=%b",
                     i, seg, an, frame_done, pending, e_seg, e_an, e_fd, e_pend);
         end
         value = $urandom;
         load  = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 199) == 0);
      end
      load = 1'b0; reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scan_walk();
      test_load_midframe();
      test_overwrite();
      test_load_on_boundary();
      test_reset_midframe();
      test_blank();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running at 1ms, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
